// File: rtl/fft_pkg.sv
// Shared FFT front-end constants and encodings used by the sample-bank routing logic.
package fft_pkg;

    localparam int unsigned SAMPLE_WIDTH = 32;
    localparam int unsigned FFT_LEN      = 64;
    localparam int unsigned FFT_LOG2     = 6;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_e;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mod_counter.sv
// Mod-MODULUS up counter with enable, synchronous clear and a wrap flag.
// Clear and enable in the same cycle counts from zero, so the cleared value is consumed.
module mod_counter #(
    parameter int unsigned MODULUS = 64,
    parameter int unsigned WIDTH   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic at_end,
    output logic wrap
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_eff;

    always_comb begin
        cnt_eff = clear ? '0 : cnt_q;
        at_end  = (cnt_eff == MaxVal);
        wrap    = en & at_end;
        cnt_d   = cnt_eff;
        if (en) begin
            cnt_d = at_end ? '0 : cnt_eff + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_demux_1_to_2.sv
// Steers whole frames alternately to two ping-pong bank ports through one
// registered valid/ready stage with pass-through ready.
module frame_demux_1_to_2
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
    parameter int unsigned FRAME_LEN  = FFT_LEN,
    parameter int unsigned CNT_WIDTH  = FFT_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  d_valid,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [DATA_WIDTH-1:0] y1,
    output logic                  y0_valid,
    output logic                  y1_valid,
    input  logic                  y0_ready,
    input  logic                  y1_ready,
    output logic                  y0_last,
    output logic                  y1_last,
    output logic                  bank,
    output logic                  frame_done
);

    out_state_e            state_q, state_d;
    bank_e                 bank_q, bank_d, bank_eff, dest_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q, frame_done_q;
    logic                  v, out_ready, fire_out, fire_in, at_end, wrap;

    mod_counter #(
        .MODULUS (FRAME_LEN),
        .WIDTH   (CNT_WIDTH)
    ) u_sample_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (sync),
        .en     (fire_in),
        .at_end (at_end),
        .wrap   (wrap)
    );

    assign v = (state_q == StFull);

    always_comb begin
        bank_eff  = sync ? BANK0 : bank_q;
        out_ready = (dest_q == BANK1) ? y1_ready : y0_ready;
        fire_out  = v & out_ready;
        // Only the selected port's ready matters; a stalled port blocks input.
        d_ready   = ~v | out_ready;
        fire_in   = d_valid & d_ready;
        bank_d    = bank_eff;
        if (wrap) begin
            bank_d = bank_e'(~bank_eff);
        end
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (fire_in) state_d = StFull;
            StFull:  if (fire_out && !fire_in) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            bank_q       <= BANK0;
            dest_q       <= BANK0;
            data_q       <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            frame_done_q <= fire_out & last_q;
            if (fire_in) begin
                data_q <= d;
                dest_q <= bank_eff;
                last_q <= at_end;
            end
        end
    end

    assign y0         = data_q;
    assign y1         = data_q;
    assign y0_valid   = v & (dest_q == BANK0);
    assign y1_valid   = v & (dest_q == BANK1);
    assign y0_last    = last_q;
    assign y1_last    = last_q;
    assign bank       = bank_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_demux_1_to_2.sv
// Directed and randomized-handshake bench for the frame demultiplexer.
module tb_frame_demux_1_to_2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic [31:0] d = '0;
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic [31:0] y0, y1;
    logic        y0_valid, y1_valid;
    logic        y0_ready = 1'b1;
    logic        y1_ready = 1'b1;
    logic        y0_last, y1_last;
    logic        bank, frame_done;

    int errors = 0;
    int checks = 0;

    frame_demux_1_to_2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .d          (d),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .y0         (y0),
        .y1         (y1),
        .y0_valid   (y0_valid),
        .y1_valid   (y1_valid),
        .y0_ready   (y0_ready),
        .y1_ready   (y1_ready),
        .y0_last    (y0_last),
        .y1_last    (y1_last),
        .bank       (bank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n = 1'b0; sync = 1'b0; d_valid = 1'b0; d = '0;
        y0_ready = 1'b1; y1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] val);
        d = val; d_valid = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({y0_valid, y1_valid, d_ready, bank, frame_done, y0_last, y1_last} !== 7'b0010000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0010000",
                     {y0_valid, y1_valid, d_ready, bank, frame_done, y0_last, y1_last});
        end
        checks++;
        if (y0 !== 32'h0 || y1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got y0=%h y1=%h expected 0", y0, y1);
        end
        do_reset();
    endtask

    task automatic test_stream;
        int fd = 0;
        do_reset();
        for (int i = 0; i < 128; i++) begin
            logic       port;
            logic       exp_last;
            logic       got_last;
            logic [1:0] exp_v;
            send(32'(i));
            port     = ((i / 64) % 2) == 1;
            exp_last = (i % 64) == 63;
            exp_v    = port ? 2'b01 : 2'b10;
            got_last = port ? y1_last : y0_last;
            checks++;
            if ({y0_valid, y1_valid} !== exp_v) begin
                errors++;
                $display("FAIL stream_port[%0d]: got %b expected %b", i, {y0_valid, y1_valid}, exp_v);
            end
            checks++;
            if (y0 !== 32'(i) || y1 !== 32'(i)) begin
                errors++;
                $display("FAIL stream_data[%0d]: got %h/%h expected %h", i, y0, y1, i);
            end
            checks++;
            if (got_last !== exp_last) begin
                errors++;
                $display("FAIL stream_last[%0d]: got %b expected %b", i, got_last, exp_last);
            end
            checks++;
            if (bank !== 1'(((i + 1) / 64) % 2)) begin
                errors++;
                $display("FAIL stream_bank[%0d]: got %b expected %0d", i, bank, ((i + 1) / 64) % 2);
            end
            checks++;
            if (frame_done !== (i == 64)) begin
                errors++;
                $display("FAIL stream_done[%0d]: got %b expected %b", i, frame_done, i == 64);
            end
            if (frame_done) fd++;
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (frame_done) fd++;
        end
        checks++;
        if (fd != 2) begin
            errors++;
            $display("FAIL stream_done_count: got %0d expected 2", fd);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        for (int i = 0; i <= 10; i++) send(32'(i));
        y0_ready = 1'b0; y1_ready = 1'b1;
        d = 32'd11; d_valid = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_initial: got %b expected 0", d_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (d_ready !== 1'b0 || y0_valid !== 1'b1 || y0 !== 32'd10) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ready=%b v=%b y0=%h expected 0 1 a",
                         c, d_ready, y0_valid, y0);
            end
        end
        y0_ready = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", d_ready);
        end
        @(posedge clk); #1;
        d_valid = 1'b0;
        checks++;
        if (y0_valid !== 1'b1 || y0 !== 32'd11) begin
            errors++;
            $display("FAIL bp_next: got v=%b y0=%h expected 1 b", y0_valid, y0);
        end
        @(posedge clk); #1;
        checks++;
        if (y0_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %b expected 0", y0_valid);
        end
    endtask

    task automatic test_sync_fire;
        do_reset();
        for (int i = 0; i < 84; i++) send(32'(i));
        sync = 1'b1;
        send(32'd84);
        sync = 1'b0;
        checks++;
        if ({y0_valid, y1_valid, y0_last, bank} !== 4'b1000 || y0 !== 32'd84) begin
            errors++;
            $display("FAIL sync_fire_first: got %b y0=%h expected 1000 y0=54",
                     {y0_valid, y1_valid, y0_last, bank}, y0);
        end
        for (int j = 1; j < 64; j++) begin
            send(32'(84 + j));
            checks++;
            if ({y0_valid, y1_valid, y0_last} !== {2'b10, j == 63}) begin
                errors++;
                $display("FAIL sync_fire_seq[%0d]: got %b expected %b",
                         j, {y0_valid, y1_valid, y0_last}, {2'b10, j == 63});
            end
        end
        checks++;
        if (bank !== 1'b1) begin
            errors++;
            $display("FAIL sync_fire_bank: got %b expected 1", bank);
        end
    endtask

    task automatic test_sync_idle;
        do_reset();
        for (int i = 0; i < 70; i++) send(32'(i));
        y1_ready = 1'b0;
        checks++;
        if (bank !== 1'b1) begin
            errors++;
            $display("FAIL sync_idle_pre_bank: got %b expected 1", bank);
        end
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        checks++;
        if ({y0_valid, y1_valid, y1_last, bank} !== 4'b0100 || y1 !== 32'd69) begin
            errors++;
            $display("FAIL sync_idle_hold: got %b y1=%h expected 0100 y1=45",
                     {y0_valid, y1_valid, y1_last, bank}, y1);
        end
        y1_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (y1_valid !== 1'b0) begin
            errors++;
            $display("FAIL sync_idle_exit: got %b expected 0", y1_valid);
        end
        send(32'h100);
        checks++;
        if ({y0_valid, y1_valid, y0_last} !== 3'b100 || y0 !== 32'h100) begin
            errors++;
            $display("FAIL sync_idle_restart: got %b y0=%h expected 100 y0=100",
                     {y0_valid, y1_valid, y0_last}, y0);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int i = 0; i <= 30; i++) send(32'(i));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({y0_valid, y1_valid, d_ready, bank} !== 4'b0010 || y0 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got %b y0=%h expected 0010 y0=0",
                     {y0_valid, y1_valid, d_ready, bank}, y0);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'hA5A5_0001);
        checks++;
        if ({y0_valid, y1_valid, y0_last} !== 3'b100 || y0 !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL async_reset_restart: got %b y0=%h expected 100 y0=a5a50001",
                     {y0_valid, y1_valid, y0_last}, y0);
        end
    endtask

    task automatic test_random;
        int  sent = 0, got0 = 0, got1 = 0, nxt0 = 0, nxt1 = 64;
        int  lasts0 = 0, lasts1 = 0, cyc = 0;
        logic in_f;
        do_reset();
        while ((got0 + got1) < 640 && cyc < 20000) begin
            d        = 32'(sent);
            d_valid  = (sent < 640) && ($urandom_range(0, 3) != 0);
            y0_ready = $urandom_range(0, 3) != 0;
            y1_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            checks++;
            if (y0_valid && y1_valid) begin
                errors++;
                $display("FAIL rand_both_valid: got 11 expected at most one");
            end
            if (y0_valid && y0_ready) begin
                checks++;
                if (y0 !== 32'(nxt0) || y0_last !== ((nxt0 % 64) == 63)) begin
                    errors++;
                    $display("FAIL rand_y0: got %h last=%b expected %h last=%b",
                             y0, y0_last, nxt0, (nxt0 % 64) == 63);
                end
                if (y0_last) lasts0++;
                got0++;
                nxt0 = ((nxt0 % 64) == 63) ? nxt0 + 65 : nxt0 + 1;
            end
            if (y1_valid && y1_ready) begin
                checks++;
                if (y1 !== 32'(nxt1) || y1_last !== ((nxt1 % 64) == 63)) begin
                    errors++;
                    $display("FAIL rand_y1: got %h last=%b expected %h last=%b",
                             y1, y1_last, nxt1, (nxt1 % 64) == 63);
                end
                if (y1_last) lasts1++;
                got1++;
                nxt1 = ((nxt1 % 64) == 63) ? nxt1 + 65 : nxt1 + 1;
            end
            in_f = d_valid && d_ready;
            @(posedge clk); #1;
            if (in_f) sent++;
            cyc++;
        end
        d_valid = 1'b0;
        checks++;
        if (got0 != 320 || got1 != 320 || lasts0 != 5 || lasts1 != 5) begin
            errors++;
            $display("FAIL rand_totals: got %0d/%0d samples %0d/%0d lasts expected 320/320 5/5",
                     got0, got1, lasts0, lasts1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_sync_fire();
        test_sync_idle();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_demux_1_to_2.md
# frame_demux_1_to_2

Routes a single sample stream into two output streams, one whole frame at a time. Frame k goes to port 0, frame k+1 to port 1, and so on alternately. It sits at the FFT input, ahead of the two ping-pong sample banks: one bank fills while the other is being transformed. The later bank-read select (a 2:1 mux) merges the two banks back into one stream. Ports 0 and 1 use a valid/ready handshake with one registered output stage.

## Interface
- DATA_WIDTH, 32: sample width (packed complex, 16-bit real and 16-bit imaginary).
- FRAME_LEN, 64: samples per frame. Must be at least 2.
- CNT_WIDTH, 6: sample counter width. Must satisfy 2^CNT_WIDTH ≥ FRAME_LEN.
- CLK  in  1  single clock. All logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SYNC  in  1  synchronous frame restart: the next accepted sample becomes sample 0 of bank 0.
- D  in  DATA_WIDTH  input sample.
- D_VALID  in  1  input sample valid.
- D_READY  out  1  block can accept a sample.
- Y0, Y1  out  DATA_WIDTH  output data. Both ports carry the same registered sample.
- Y0_VALID, Y1_VALID  out  1  held sample is valid and is destined for that port.
- Y0_READY, Y1_READY  in  1  downstream accepts.
- Y0_LAST, Y1_LAST  out  1  held sample is the last sample of its frame. Qualified by the matching VALID.
- BANK  out  1  bank the next accepted input sample will go to.
- FRAME_DONE  out  1  one-cycle pulse when a LAST sample is accepted downstream.

## Operation
- Internal state:
  - cnt: CNT_WIDTH bits.
  - bank: 1 bit.
  - Output register: data, dest, last, v.
- States: EMPTY (v=0) and FULL (v=1).
- Definitions:
  - out_ready = dest ? Y1_READY : Y0_READY.
  - fire_out = v & out_ready.
  - D_READY = ~v | out_ready (combinational, pass-through ready).
  - fire_in = D_VALID & D_READY.
- On fire_in:
  - Load data←D, dest←bank_eff, last←(cnt_eff == FRAME_LEN-1), v←1.
  - cnt_eff/bank_eff are cnt/bank, or 0/0 if SYNC=1 in the same cycle.
- Counter and bank update:
  - Counter advances on fire_in.
  - On cnt_eff == FRAME_LEN-1: cnt←0 and bank←~bank_eff.
  - Otherwise: cnt←cnt_eff+1 and bank←bank_eff.
- Register drain: fire_out without fire_in sets v←0. fire_out together with fire_in reloads the register (FULL→FULL, no bubble).
- Output valids: Y0_VALID = v & ~dest and Y1_VALID = v & dest. Never both high.
- Ready isolation: a READY on the non-selected port is ignored. A stalled port blocks the input, even when the other port is ready.
- SYNC without fire_in: cnt←0, bank←0. The held output sample and its dest/last are unchanged.
- BANK = bank (registered). The SYNC override is not reflected until the next cycle.
- FRAME_DONE is registered. It is set in the cycle after fire_out & last.
- FULL, no fire_out: D_READY=0, so there is no overwrite. Output data, dest and last stay stable while VALID is high.

## Timing
- Reset (RST_N low, asynchronous): cnt=0, bank=0, v=0, dest=0, last=0, data=0, FRAME_DONE=0.
  - So Y0_VALID=Y1_VALID=0, Y0=Y1=0, BANK=0, D_READY=1.
- Latency is 1 cycle: a sample accepted at edge n is valid on its port after edge n.
- Throughput is 1 sample per cycle when the destination port holds READY high.
- Frame boundary: sample FRAME_LEN-1 of bank b is presented with LAST=1. The very next accepted sample goes to bank ~b with no dead cycle.
- Reset asserted mid-frame drops the held sample and the partial frame. The next frame after release starts on bank 0, sample 0.

## Structure
- Shared package fft_pkg holds:
  - The sample width constant (32).
  - The FFT frame length (64) and its log2 (6).
  - The bank encoding: BANK0=0, BANK1=1.
- One sub-module: mod_counter. It is a mod-FRAME_LEN up counter with enable, synchronous clear and a wrap flag. It is instantiated for cnt, and its wrap flag toggles bank.
- Everything else stays inline: the output register and the handshake logic.

## Test plan
- Reset then stream 128 samples with D=0..127, both READY=1, SYNC=0:
  - Samples 0..63 appear on Y0 and 64..127 on Y1, one cycle after acceptance.
  - LAST is set on 63 and 127. FRAME_DONE pulses twice.
  - BANK reads 1 after sample 63 is accepted and 0 after sample 127.
- Backpressure: Y0_READY=0 for 5 cycles while sample 10 is held.
  - D_READY=0 and Y0 stays 10 throughout. Y1_READY=1 has no effect.
  - On release, samples 10 and 11 flow with no loss or duplication.
- SYNC at sample 20 of bank 1, asserted in the same cycle as fire_in:
  - That sample goes to Y0 as sample 0.
  - LAST appears 63 samples later, not at the old boundary.
- SYNC with D_VALID=0 while sample 5 is held: the held sample still exits on its original port, and BANK=0 next cycle.
- RST_N pulsed low asynchronously mid-frame at sample 30:
  - Both VALIDs drop immediately and D_READY=1.
  - After release, D=0xA5A5_0001 appears on Y0 with no LAST.
- Random valid/ready toggling (≥50% duty) over 10 frames:
  - The scoreboard matches per-port order.
  - Every frame is exactly 64 samples with a single LAST.
